// File: rtl/rca_chunk_serial_if.sv
// Start/busy/done handshake and operand/result bus for the chunk-serial adder.
interface rca_chunk_serial_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/rca_chunk_serial.sv
// Multi-cycle ripple-carry adder/subtractor: CHUNK bits per clock, LSB chunk first,
// with a registered carry linking consecutive chunks.
module rca_chunk_serial #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic              clk,
    input  logic              rst,
    rca_chunk_serial_if.slave bus
);
    localparam int unsigned NCH = WIDTH / CHUNK;
    localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_n;
    logic [CW-1:0]     cnt_q, cnt_n;
    logic              carry_q, carry_n;
    logic [WIDTH-1:0]  a_q, a_n;
    logic [WIDTH-1:0]  b_q, b_n;
    logic [WIDTH-1:0]  res_q, res_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;
    logic [WIDTH-1:0]  sum_q, sum_n;
    logic              cout_q, cout_n;
    logic              ovf_q, ovf_n;

    logic [31:0]       base;
    logic [CHUNK-1:0]  sl_a, sl_b, sl_s;
    logic [CHUNK:0]    sl_c;

    // One CHUNK-bit ripple slice of full adders fed by the current chunk
    always_comb begin
        base    = 32'(cnt_q) * CHUNK;
        sl_a    = a_q[base +: CHUNK];
        sl_b    = b_q[base +: CHUNK];
        sl_c    = '0;
        sl_s    = '0;
        sl_c[0] = carry_q;
        for (int i = 0; i < int'(CHUNK); i++) begin
            sl_s[i]   = sl_a[i] ^ sl_b[i] ^ sl_c[i];
            sl_c[i+1] = (sl_a[i] & sl_b[i]) | (sl_b[i] & sl_c[i]) | (sl_a[i] & sl_c[i]);
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        carry_n = carry_q;
        a_n     = a_q;
        b_n     = b_q;
        res_n   = res_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        sum_n   = sum_q;
        cout_n  = cout_q;
        ovf_n   = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_n     = bus.a;
                    b_n     = bus.sub ? ~bus.b : bus.b;
                    carry_n = bus.cin ^ bus.sub;
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                res_n[base +: CHUNK] = sl_s;
                carry_n              = sl_c[CHUNK];
                cnt_n                = cnt_q + CW'(1);
                // Publish only complete results; intermediate chunks stay internal
                if (cnt_q == CW'(NCH - 1)) begin
                    sum_n   = res_n;
                    cout_n  = sl_c[CHUNK];
                    ovf_n   = sl_c[CHUNK] ^ sl_c[CHUNK-1];
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset also aborts an operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            carry_q <= carry_n;
            a_q     <= a_n;
            b_q     <= b_n;
            res_q   <= res_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            sum_q   <= sum_n;
            cout_q  <= cout_n;
            ovf_q   <= ovf_n;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule
